// File: rtl/mem_responder.sv
// mem_responder: memory-side end of the multicycle CPU load/store port.
// Accepts one request at a time, waits LATENCY cycles, then performs a
// byte/halfword/word access on an internal word array and returns a
// single-cycle response with zero-extended read data or an error flag.
module mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error
);

  localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);
  localparam logic [3:0]  LAST_WAIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  wait_cnt;
  logic [3:0]  wait_cnt_nxt;

  // Latched request, held from acceptance until the access edge
  logic        write_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic [31:0] mem [DEPTH_WORDS];

  // Operands of the access: live request when accepting straight into RESP
  // (LATENCY=0), otherwise the latched copy
  logic        op_write;
  logic [1:0]  op_size;
  logic [31:0] op_addr;
  logic [31:0] op_wdata;
  logic        op_err;
  logic [AW-1:0] op_idx;
  logic [31:0] cur_word;
  logic        access_en;

  // Any misalignment, out-of-range word index or illegal size
  function automatic logic req_err(input logic [1:0] size, input logic [31:0] addr);
    logic e;
    e = 1'b0;
    if (size == SIZE_ILL) e = 1'b1;
    if ((size == SIZE_HALF) && addr[0]) e = 1'b1;
    if ((size == SIZE_WORD) && (addr[1:0] != 2'b00)) e = 1'b1;
    if (addr[31:2] >= DEPTH_LIM) e = 1'b1;
    return e;
  endfunction

  // Read-modify-write merge: only the addressed lanes take store data
  function automatic logic [31:0] store_merge(input logic [31:0] old_word,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  size,
                                              input logic [1:0]  off);
    logic [31:0] mask;
    logic [31:0] shifted;
    case (size)
      SIZE_BYTE: mask = 32'h0000_00FF << {off, 3'b000};
      SIZE_HALF: mask = 32'h0000_FFFF << {off, 3'b000};
      default:   mask = 32'hFFFF_FFFF;
    endcase
    shifted = wdata << {off, 3'b000};
    return (old_word & ~mask) | (shifted & mask);
  endfunction

  // Right-align the addressed lanes and zero-extend to 32 bits
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off);
    logic [31:0] shifted;
    shifted = word >> {off, 3'b000};
    case (size)
      SIZE_BYTE: return {24'h000000, shifted[7:0]};
      SIZE_HALF: return {16'h0000, shifted[15:0]};
      default:   return shifted;
    endcase
  endfunction

  // Operand selection and access decode
  always_comb begin
    op_write = write_q;
    op_size  = size_q;
    op_addr  = addr_q;
    op_wdata = wdata_q;
    if (state == IDLE) begin
      op_write = req_write;
      op_size  = req_size;
      op_addr  = req_addr;
      op_wdata = req_wdata;
    end
    op_err    = req_err(op_size, op_addr);
    op_idx    = op_addr[AW+1:2];
    cur_word  = op_err ? 32'h0 : mem[op_idx];
    access_en = (state_nxt == RESP) && (state != RESP) && !reset;
  end

  // Next-state logic and wait counter
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      IDLE: begin
        if (req_valid) begin
          wait_cnt_nxt = 4'd0;
          if (LATENCY > 0) state_nxt = WAIT;
          else             state_nxt = RESP;
        end
      end
      WAIT: begin
        wait_cnt_nxt = wait_cnt + 4'd1;
        if (wait_cnt == LAST_WAIT) state_nxt = RESP;
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Control state and response registers; response holds between strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      wait_cnt   <= 4'd0;
      resp_rdata <= 32'h0;
      resp_error <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (access_en) begin
        resp_error <= op_err;
        resp_rdata <= (op_err || op_write) ? 32'h0
                                           : load_extract(cur_word, op_size, op_addr[1:0]);
      end
    end
  end

  // Capture the request on acceptance
  always_ff @(posedge clk) begin
    if ((state == IDLE) && req_valid) begin
      write_q <= req_write;
      size_q  <= req_size;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Array write at the edge entering RESP; errors and reset suppress it
  always_ff @(posedge clk) begin
    if (access_en && op_write && !op_err) begin
      mem[op_idx] <= store_merge(cur_word, op_wdata, op_size, op_addr[1:0]);
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one instance with LATENCY=2 (a_*) and one with
// LATENCY=0 (z_*). Stimulus pushes expected responses into per-instance
// queues; monitors pop and compare whenever resp_valid is seen.
module tb_mem_responder;

  localparam logic [1:0] SB = 2'b00;
  localparam logic [1:0] SH = 2'b01;
  localparam logic [1:0] SW = 2'b10;
  localparam logic [1:0] SX = 2'b11;

  logic        clk;
  logic        a_rst, z_rst;
  logic        a_req_valid, a_req_ready, a_req_write, a_resp_valid, a_resp_error;
  logic [1:0]  a_req_size;
  logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata;
  logic        z_req_valid, z_req_ready, z_req_write, z_resp_valid, z_resp_error;
  logic [1:0]  z_req_size;
  logic [31:0] z_req_addr, z_req_wdata, z_resp_rdata;

  logic [32:0] q_a[$];
  logic [32:0] q_z[$];
  int n_checks = 0;
  int n_fail   = 0;

  mem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) dut_a (
    .clk(clk), .reset(a_rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
    .req_size(a_req_size), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata), .resp_error(a_resp_error)
  );

  mem_responder #(.DEPTH_WORDS(64), .LATENCY(0)) dut_z (
    .clk(clk), .reset(z_rst),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
    .req_size(z_req_size), .req_addr(z_req_addr), .req_wdata(z_req_wdata),
    .resp_valid(z_resp_valid), .resp_rdata(z_resp_rdata), .resp_error(z_resp_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic get_ready(input bit inst);
    return inst ? z_req_ready : a_req_ready;
  endfunction

  function automatic logic get_valid(input bit inst);
    return inst ? z_resp_valid : a_resp_valid;
  endfunction

  task automatic drive(input bit inst, input bit v, input bit w, input logic [1:0] s,
                       input logic [31:0] ad, input logic [31:0] d);
    if (inst) begin
      z_req_valid = v; z_req_write = w; z_req_size = s; z_req_addr = ad; z_req_wdata = d;
    end else begin
      a_req_valid = v; a_req_write = w; a_req_size = s; a_req_addr = ad; a_req_wdata = d;
    end
  endtask

  // One transaction with exact handshake timing checked each cycle
  task automatic req(input bit inst, input int lat, input bit w, input logic [1:0] s,
                     input logic [31:0] ad, input logic [31:0] d,
                     input logic [31:0] er, input bit ee);
    @(negedge clk);
    check("ready_before_req", 32'(get_ready(inst)), 32'd1);
    drive(inst, 1'b1, w, s, ad, d);
    if (inst) q_z.push_back({ee, er});
    else      q_a.push_back({ee, er});
    @(posedge clk);
    #1;
    drive(inst, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    for (int k = 1; k <= lat + 2; k++) begin
      @(negedge clk);
      check($sformatf("ready_c%0d_%0h", k, ad), 32'(get_ready(inst)), 32'(k == lat + 2));
      check($sformatf("valid_c%0d_%0h", k, ad), 32'(get_valid(inst)), 32'(k == lat + 1));
    end
  endtask

  // Monitor for the LATENCY=2 instance
  always @(negedge clk) begin
    if (a_resp_valid === 1'b1) begin
      if (q_a.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL a_unexpected_resp: got resp_valid=1 rdata=%h required no response", a_resp_rdata);
      end else begin
        logic [32:0] e;
        e = q_a.pop_front();
        check("a_rdata", a_resp_rdata, e[31:0]);
        check("a_error", 32'(a_resp_error), 32'(e[32]));
      end
    end
  end

  // Monitor for the LATENCY=0 instance
  always @(negedge clk) begin
    if (z_resp_valid === 1'b1) begin
      if (q_z.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL z_unexpected_resp: got resp_valid=1 rdata=%h required no response", z_resp_rdata);
      end else begin
        logic [32:0] e;
        e = q_z.pop_front();
        check("z_rdata", z_resp_rdata, e[31:0]);
        check("z_error", 32'(z_resp_error), 32'(e[32]));
      end
    end
  end

  initial begin
    a_rst = 1'b1;
    z_rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_a_ready", 32'(a_req_ready), 32'd1);
    check("rst_a_valid", 32'(a_resp_valid), 32'd0);
    check("rst_a_rdata", a_resp_rdata, 32'h0);
    check("rst_a_error", 32'(a_resp_error), 32'd0);
    check("rst_z_ready", 32'(z_req_ready), 32'd1);
    check("rst_z_valid", 32'(z_resp_valid), 32'd0);
    a_rst = 1'b0;
    z_rst = 1'b0;

    // Word store then load
    req(0, 2, 1, SW, 32'h10, 32'hDEADBEEF, 32'h0, 0);
    req(0, 2, 0, SW, 32'h10, 32'h0, 32'hDEADBEEF, 0);

    // Byte / halfword lanes
    req(0, 2, 1, SW, 32'h20, 32'h11223344, 32'h0, 0);
    req(0, 2, 1, SB, 32'h21, 32'hFFFFFFAA, 32'h0, 0);
    req(0, 2, 0, SW, 32'h20, 32'h0, 32'h1122AA44, 0);
    req(0, 2, 0, SH, 32'h22, 32'h0, 32'h00001122, 0);
    req(0, 2, 0, SB, 32'h23, 32'h0, 32'h00000011, 0);
    req(0, 2, 0, SB, 32'h21, 32'h0, 32'h000000AA, 0);
    req(0, 2, 0, SH, 32'h20, 32'h0, 32'h0000AA44, 0);
    req(0, 2, 1, SH, 32'h22, 32'h12345566, 32'h0, 0);
    req(0, 2, 0, SW, 32'h20, 32'h0, 32'h5566AA44, 0);

    // Errors leave memory untouched and return rdata 0
    req(0, 2, 1, SW, 32'h00, 32'h01020304, 32'h0, 0);
    req(0, 2, 1, SW, 32'h04, 32'h05060708, 32'h0, 0);
    req(0, 2, 0, SW, 32'h02, 32'h0, 32'h0, 1);
    req(0, 2, 0, SW, 32'h00, 32'h0, 32'h01020304, 0);
    req(0, 2, 1, SH, 32'h05, 32'h0000BEEF, 32'h0, 1);
    req(0, 2, 0, SW, 32'h04, 32'h0, 32'h05060708, 0);
    req(0, 2, 1, SX, 32'h00, 32'hFFFFFFFF, 32'h0, 1);
    req(0, 2, 0, SW, 32'h00, 32'h0, 32'h01020304, 0);
    req(0, 2, 0, SX, 32'h04, 32'h0, 32'h0, 1);
    req(0, 2, 1, SW, 32'h100, 32'hA5A5A5A5, 32'h0, 1);
    req(0, 2, 0, SW, 32'h00, 32'h0, 32'h01020304, 0);
    req(0, 2, 0, SW, 32'h100, 32'h0, 32'h0, 1);
    req(0, 2, 0, SH, 32'h22, 32'h0, 32'h00005566, 0);

    // Reset during WAIT abandons the store
    req(0, 2, 1, SW, 32'h08, 32'h00000000, 32'h0, 0);
    req(0, 2, 0, SW, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    @(negedge clk);
    drive(0, 1'b1, 1'b1, SW, 32'h08, 32'h12345678);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    @(negedge clk);
    check("rw_wait_ready", 32'(a_req_ready), 32'd0);
    check("rw_wait_valid", 32'(a_resp_valid), 32'd0);
    a_rst = 1'b1;
    @(negedge clk);
    a_rst = 1'b0;
    check("rw_after_ready", 32'(a_req_ready), 32'd1);
    check("rw_after_valid", 32'(a_resp_valid), 32'd0);
    check("rw_after_rdata", a_resp_rdata, 32'h0);
    check("rw_after_error", 32'(a_resp_error), 32'd0);
    repeat (4) begin
      @(negedge clk);
      check("rw_no_resp", 32'(a_resp_valid), 32'd0);
    end
    req(0, 2, 0, SW, 32'h08, 32'h0, 32'h00000000, 0);

    // Reset during RESP
    @(negedge clk);
    drive(0, 1'b1, 1'b0, SW, 32'h10, 32'h0);
    q_a.push_back({1'b0, 32'hDEADBEEF});
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    check("rr_resp_valid", 32'(a_resp_valid), 32'd1);
    a_rst = 1'b1;
    @(negedge clk);
    a_rst = 1'b0;
    check("rr_after_valid", 32'(a_resp_valid), 32'd0);
    check("rr_after_ready", 32'(a_req_ready), 32'd1);
    check("rr_after_rdata", a_resp_rdata, 32'h0);
    req(0, 2, 0, SW, 32'h20, 32'h0, 32'h5566AA44, 0);

    // LATENCY=0 instance
    req(1, 0, 1, SW, 32'h40, 32'hCAFEF00D, 32'h0, 0);
    req(1, 0, 1, SW, 32'h44, 32'h0BADC0DE, 32'h0, 0);
    req(1, 0, 0, SH, 32'h42, 32'h0, 32'h0000CAFE, 0);
    req(1, 0, 0, SH, 32'h41, 32'h0, 32'h0, 1);

    // Back-to-back loads with req_valid held high through the busy cycle
    @(negedge clk);
    drive(1, 1'b1, 1'b0, SW, 32'h40, 32'h0);
    q_z.push_back({1'b0, 32'hCAFEF00D});
    @(negedge clk);
    check("b2b_c1_ready", 32'(z_req_ready), 32'd0);
    check("b2b_c1_valid", 32'(z_resp_valid), 32'd1);
    @(negedge clk);
    check("b2b_c2_ready", 32'(z_req_ready), 32'd1);
    check("b2b_c2_valid", 32'(z_resp_valid), 32'd0);
    drive(1, 1'b1, 1'b0, SW, 32'h44, 32'h0);
    q_z.push_back({1'b0, 32'h0BADC0DE});
    @(negedge clk);
    check("b2b_c3_ready", 32'(z_req_ready), 32'd0);
    check("b2b_c3_valid", 32'(z_resp_valid), 32'd1);
    drive(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    @(negedge clk);
    check("b2b_c4_ready", 32'(z_req_ready), 32'd1);
    check("b2b_c4_valid", 32'(z_resp_valid), 32'd0);
    @(negedge clk);
    check("b2b_c5_valid", 32'(z_resp_valid), 32'd0);

    repeat (3) @(negedge clk);
    check("q_a_drained", 32'(q_a.size()), 32'd0);
    check("q_z_drained", 32'(q_z.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
